bit_deserializer: RTL
=====================

# bit_deserializer

Serial-to-parallel front end for the priority encoder. It collects a 1-bit serial stream, qualified by a valid strobe, into WIDTH-bit words and presents each completed word with a single-cycle valid pulse. It sits directly upstream of `priority_encoder` and drives its `data_i`/`data_val_i`. A flush input emits a partial word, zero-padded, so a stream can be closed without padding it by hand.

## Interface
- `WIDTH`, 5: output word width; must match the downstream encoder; ≥ 2.
- `MSB_FIRST`, 1: 1 = first received bit lands in bit WIDTH-1; 0 = first bit lands in bit 0.
- `clk_i`  in  1: clock; all logic on rising edge.
- `srst_i`  in  1: reset, synchronous, active-high.
- `data_i`  in  1: serial data bit; sampled only when `data_val_i`=1.
- `data_val_i`  in  1: qualifies `data_i`.
- `flush_i`  in  1: close the current partial word at this edge.
- `deser_data_o`  out  WIDTH: assembled word; holds its value between pulses.
- `deser_data_val_o`  out  1: one-cycle pulse, word valid.
- `deser_len_o`  out  $clog2(WIDTH+1): number of received bits in `deser_data_o` (WIDTH for a full word).
- `busy_o`  out  1: high while a partial word is held (bit count > 0).

## Operation
- Internal state:
  - shift/assembly register `shreg[WIDTH-1:0]`;
  - bit counter `cnt`, range 0..WIDTH-1;
  - no other FSM; the notional states are EMPTY (cnt=0) and FILLING (cnt>0).
- On an edge with `data_val_i`=1, the bit is written:
  - MSB_FIRST=1: `shreg` shifts left, new bit enters bit 0.
  - MSB_FIRST=0: bit is written at index `cnt`.
  - `cnt` increments.
- **Full word:** when the bit just sampled is the WIDTH-th, at that same edge:
  - `deser_data_o` ← completed word;
  - `deser_len_o` ← WIDTH;
  - `deser_data_val_o` ← 1;
  - `cnt` ← 0 and `shreg` ← 0.
- **Flush:** `flush_i`=1 with a non-zero count after including any simultaneous valid bit emits the partial word of length n.
  - MSB_FIRST=1: bits are left-aligned (first bit at WIDTH-1) and zero-filled below.
  - MSB_FIRST=0: bits occupy [n-1:0], zeros above.
  - `deser_len_o` ← n, pulse asserted, `cnt`/`shreg` cleared.
- Flush with count 0 and `data_val_i`=0: no pulse, outputs unchanged.
- Flush and `data_val_i` in the same cycle: the bit is included first, then the flush applies.
  - If that bit completes a word, the result is one normal full-word emission, not two.
- `data_val_i`=0 without flush: state holds; gaps of any length are allowed mid-word.
- `deser_data_val_o` is deasserted on every edge without an emission.

## Timing
- Reset (`srst_i`=1 at an edge):
  - `deser_data_o`=0, `deser_data_val_o`=0, `deser_len_o`=0, `busy_o`=0;
  - `cnt`=0, `shreg`=0.
- Reset mid-word discards the partial word; no flush emission occurs. Reset overrides `data_val_i`/`flush_i` in the same cycle.
- Latency: outputs are registered at the edge that samples the last bit (or the flush). The pulse is visible for exactly the following cycle.
- Back-to-back throughput: continuous `data_val_i` gives one pulse every WIDTH cycles. Bit 0 of the next word may be sampled on the cycle the previous pulse is visible.
- No backpressure; the downstream stage must accept every pulse.
- `busy_o` is combinational from `cnt` (cnt≠0), so it reflects state after the edge.

## Structure
- Shared package `priority_encoder_pkg`:
  - `DEFAULT_WIDTH` = 5, used by both this block and the encoder;
  - `localparam`-style helper `LEN_W(width) = $clog2(width+1)`.
- Single module; no sub-module is warranted. Counter, assembly register, and output register are inline.
- Top-level chain instantiates `bit_deserializer` → `priority_encoder`, with `deser_data_o`/`deser_data_val_o` driving `data_i`/`data_val_i`.

## Test plan
- WIDTH=5, MSB_FIRST=1, bits 1,0,1,1,0 on consecutive cycles → one pulse with `deser_data_o`=5'b10110, `deser_len_o`=5; `busy_o` high for 4 cycles.
- WIDTH=5, MSB_FIRST=0, same bits → `deser_data_o`=5'b01101, `deser_len_o`=5.
- MSB_FIRST=1, bits 1,1,0, then `flush_i` alone → `deser_data_o`=5'b11000, `deser_len_o`=3. A later flush alone gives no pulse.
- Gaps: bits 1,_,0,_,_,0,0,1 (valid deasserted at `_`) → single pulse 5'b10001, `deser_len_o`=5, on the edge after the 5th valid bit.
- 15 consecutive valid bits, with `flush_i` asserted together with the 10th bit → exactly 3 pulses spaced 5 cycles apart; the flush adds no extra or short word.
- Reset after 3 bits, then bits 0,0,1,0,1 → outputs 0 during reset. The next pulse is 5'b00101 with `deser_len_o`=5; the pre-reset bits are gone.

Source files
------------

// File: rtl/priority_encoder_pkg.sv
// Shared definitions for the deserializer -> priority encoder chain.
// Both blocks take their default word width and length-field sizing from here.
package priority_encoder_pkg;

  localparam int DEFAULT_WIDTH = 5;

  function automatic int LEN_W(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/bit_deserializer.sv
// Collects a valid-qualified serial bit stream into WIDTH-bit words.
// Supports a flush that closes a partial word zero-padded.
module bit_deserializer
  import priority_encoder_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                    clk_i,
  input  logic                    srst_i,
  input  logic                    data_i,
  input  logic                    data_val_i,
  input  logic                    flush_i,
  output logic [WIDTH-1:0]        deser_data_o,
  output logic                    deser_data_val_o,
  output logic [LEN_W(WIDTH)-1:0] deser_len_o,
  output logic                    busy_o
);

  localparam int LW = LEN_W(WIDTH);
  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] r_shreg;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_data;
  logic             r_val;
  logic [LW-1:0]    r_len;

  logic [WIDTH-1:0] w_shreg_upd;
  logic [LW-1:0]    w_len_upd;
  logic [LW-1:0]    w_shamt;
  logic [WIDTH-1:0] w_word;
  logic             w_full;
  logic             w_emit;

  // The incoming bit is folded in first, so a simultaneous flush sees it.
  always_comb begin
    w_shreg_upd = r_shreg;
    w_len_upd   = LW'(r_cnt);
    if (data_val_i) begin
      if (MSB_FIRST) begin
        w_shreg_upd = {r_shreg[WIDTH-2:0], data_i};
      end else begin
        w_shreg_upd[r_cnt] = data_i;
      end
      w_len_upd = LW'(r_cnt) + LW'(1);
    end
    w_full  = (w_len_upd == LW'(WIDTH));
    w_emit  = w_full || (flush_i && (w_len_upd != '0));
    w_shamt = LW'(WIDTH) - w_len_upd;
    if (MSB_FIRST) begin
      w_word = w_shreg_upd << w_shamt;
    end else begin
      w_word = w_shreg_upd;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_shreg <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
      r_val   <= 1'b0;
      r_len   <= '0;
    end else begin
      r_val <= w_emit;
      if (w_emit) begin
        r_data  <= w_word;
        r_len   <= w_len_upd;
        r_shreg <= '0;
        r_cnt   <= '0;
      end else begin
        r_shreg <= w_shreg_upd;
        r_cnt   <= w_len_upd[CW-1:0];
      end
    end
  end

  assign deser_data_o     = r_data;
  assign deser_data_val_o = r_val;
  assign deser_len_o      = r_len;
  assign busy_o           = (r_cnt != '0);

endmodule
